vram_arb: RTL

- Cycle-level arbiter sharing one single-port video RAM (registered-output SPRAM, 1-cycle read latency) between three requesters: VGA scan-out fetch, CPU bus bridge, and a DMA/blitter port.
- Sits in the 25 MHz domain between the VRAM macro and its users, in place of fixed clock-phase interleaving.
- VGA gets a guaranteed slot every other cycle. CPU and DMA share the rest round-robin.

---
 rtl/vram_arb_if.sv | 48 ++++
 rtl/vram_arb.sv | 132 +++++++++++++
 2 files changed

// File: rtl/vram_arb_if.sv
// vram_arb_if: requester and VRAM-side signals of the video RAM arbiter.
// slave  = arbiter side, master = requesters plus the VRAM macro.
interface vram_arb_if #(
   parameter int AW = 16,
   parameter int DW = 8
);
   logic          vga_req;
   logic [AW-1:0] vga_addr;
   logic          vga_ack;
   logic          vga_rvalid;

   logic          cpu_req;
   logic [AW-1:0] cpu_addr;
   logic          cpu_we;
   logic [DW-1:0] cpu_dbw;
   logic          cpu_ack;
   logic          cpu_rvalid;

   logic          dma_req;
   logic [AW-1:0] dma_addr;
   logic          dma_we;
   logic [DW-1:0] dma_dbw;
   logic          dma_ack;
   logic          dma_rvalid;

   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_dbw;
   logic [DW-1:0] vram_dbr;   // read data goes straight from the macro to the requesters

   modport slave (
      input  vga_req, vga_addr,
      input  cpu_req, cpu_addr, cpu_we, cpu_dbw,
      input  dma_req, dma_addr, dma_we, dma_dbw,
      input  vram_dbr,
      output vga_ack, vga_rvalid, cpu_ack, cpu_rvalid, dma_ack, dma_rvalid,
      output ram_addr, ram_we, ram_dbw
   );

   modport master (
      output vga_req, vga_addr,
      output cpu_req, cpu_addr, cpu_we, cpu_dbw,
      output dma_req, dma_addr, dma_we, dma_dbw,
      output vram_dbr,
      input  vga_ack, vga_rvalid, cpu_ack, cpu_rvalid, dma_ack, dma_rvalid,
      input  ram_addr, ram_we, ram_dbw
   );
endinterface

// File: rtl/vram_arb.sv
// vram_arb: cycle-level arbiter for one registered-output single-port VRAM.
// VGA owns every phase-0 slot; CPU and DMA share the remaining bandwidth
// round-robin. Grants are decided combinationally and issued one cycle later.
// Optional stall statistics counter: define VRAM_ARB_STATS_EN.
module vram_arb #(
   parameter int AW     = 16,
   parameter int DW     = 8,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              rst,        // asynchronous, active low
   vram_arb_if.slave         bus,
   output logic [STAT_W-1:0] stall_cnt
);
   typedef enum logic {PH_VGA = 1'b0, PH_SHARED = 1'b1} phase_t;
   typedef enum logic [1:0] {G_NONE, G_VGA, G_CPU, G_DMA} grant_t;

   phase_t        phase_reg, phase_next;
   logic          rr_ptr_reg, rr_ptr_next;   // 0: CPU wins next contest, 1: DMA
   grant_t        grant;
   logic          cpu_elig, dma_elig;

   logic [AW-1:0] ram_addr_reg;
   logic          ram_we_reg;
   logic [DW-1:0] ram_dbw_reg;
   logic          vga_ack_reg, cpu_ack_reg, dma_ack_reg;
   logic          vga_rvalid_reg, cpu_rvalid_reg, dma_rvalid_reg;

   // A held request is masked during its own ack cycle so it is issued once.
   assign cpu_elig = bus.cpu_req & ~cpu_ack_reg;
   assign dma_elig = bus.dma_req & ~dma_ack_reg;

   // Slot phase and round-robin pointer register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_reg  <= PH_VGA;
         rr_ptr_reg <= 1'b0;
      end else begin
         phase_reg  <= phase_next;
         rr_ptr_reg <= rr_ptr_next;
      end
   end

   // Grant decision for this cycle and next slot phase.
   always_comb begin
      phase_next  = (phase_reg == PH_VGA) ? PH_SHARED : PH_VGA;
      rr_ptr_next = rr_ptr_reg;
      grant       = G_NONE;
      if (phase_reg == PH_VGA && bus.vga_req) begin
         grant = G_VGA;
      end else if (cpu_elig && dma_elig) begin
         grant       = rr_ptr_reg ? G_DMA : G_CPU;
         rr_ptr_next = ~rr_ptr_reg;
      end else if (cpu_elig) begin
         grant = G_CPU;
      end else if (dma_elig) begin
         grant = G_DMA;
      end else if (bus.vga_req) begin
         grant = G_VGA;   // spare shared slot goes to scan-out
      end
   end

   // Issue the granted access to the RAM and raise the matching ack/rvalid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ram_addr_reg   <= '0;
         ram_we_reg     <= 1'b0;
         ram_dbw_reg    <= '0;
         vga_ack_reg    <= 1'b0;
         cpu_ack_reg    <= 1'b0;
         dma_ack_reg    <= 1'b0;
         vga_rvalid_reg <= 1'b0;
         cpu_rvalid_reg <= 1'b0;
         dma_rvalid_reg <= 1'b0;
      end else begin
         vga_ack_reg <= (grant == G_VGA);
         cpu_ack_reg <= (grant == G_CPU);
         dma_ack_reg <= (grant == G_DMA);
         case (grant)
            G_VGA: begin
               ram_addr_reg <= bus.vga_addr;
               ram_we_reg   <= 1'b0;
            end
            G_CPU: begin
               ram_addr_reg <= bus.cpu_addr;
               ram_we_reg   <= bus.cpu_we;
               ram_dbw_reg  <= bus.cpu_dbw;
            end
            G_DMA: begin
               ram_addr_reg <= bus.dma_addr;
               ram_we_reg   <= bus.dma_we;
               ram_dbw_reg  <= bus.dma_dbw;
            end
            default: ram_we_reg <= 1'b0;   // idle: address and data hold
         endcase
         // RAM output register makes read data valid the cycle after issue.
         vga_rvalid_reg <= vga_ack_reg;
         cpu_rvalid_reg <= cpu_ack_reg & ~ram_we_reg;
         dma_rvalid_reg <= dma_ack_reg & ~ram_we_reg;
      end
   end

   assign bus.ram_addr   = ram_addr_reg;
   assign bus.ram_we     = ram_we_reg;
   assign bus.ram_dbw    = ram_dbw_reg;
   assign bus.vga_ack    = vga_ack_reg;
   assign bus.cpu_ack    = cpu_ack_reg;
   assign bus.dma_ack    = dma_ack_reg;
   assign bus.vga_rvalid = vga_rvalid_reg;
   assign bus.cpu_rvalid = cpu_rvalid_reg;
   assign bus.dma_rvalid = dma_rvalid_reg;

`ifdef VRAM_ARB_STATS_EN
   logic              stall_now;
   logic [STAT_W-1:0] stall_cnt_reg;

   assign stall_now = (cpu_elig && grant != G_CPU) || (dma_elig && grant != G_DMA);

   // Saturating count of cycles where an eligible CPU/DMA request waited.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_reg <= '0;
      end else if (stall_now && !(&stall_cnt_reg)) begin
         stall_cnt_reg <= stall_cnt_reg + {{(STAT_W-1){1'b0}}, 1'b1};
      end
   end

   assign stall_cnt = stall_cnt_reg;
`else
   assign stall_cnt = '0;
`endif
endmodule
